// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains length-prefixed frames from the async FIFO read port into a valid/ready byte stream.
// Optional inter-frame gap is compiled in with `define FRAME_READER_IFG_EN.
// A 2-entry skid buffer absorbs the FIFO's one-cycle read latency.
// The read-issue check credits this cycle's pop, so 1 byte/cycle is sustained with tx_ready high.
module fifo_frame_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_FRAME  = 1518,
    parameter int GAP_CYCLES = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_WIDTH:0] fifo_occu,
    output logic                fifo_read_enable,
    input  logic [7:0]          fifo_read_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    output logic                tx_last,
    input  logic                tx_ready,
    output logic                len_error,
    output logic                busy
);
    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, PAYLOAD, DISCARD
`ifdef FRAME_READER_IFG_EN
        , GAP
`endif
    } state_t;

    if (GAP_CYCLES < 1 || MAX_FRAME < 1) begin : g_bad_cfg
        $error("fifo_frame_reader: GAP_CYCLES and MAX_FRAME must be at least 1");
    end

    state_t          state_q, state_d;
    logic [7:0]      len_hi_q, len_hi_d;
    logic [15:0]     rem_q, rem_d;
    logic            inflight_q, inflight_d;
    logic            last_fl_q, last_fl_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [1:0][7:0] dat_q, dat_d;
    logic [1:0]      lst_q, lst_d;
    logic            len_error_q, len_error_d;
`ifdef FRAME_READER_IFG_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0]   gap_q, gap_d;
`endif

    logic [15:0] length;
    logic        len_bad, has_data, pop, push, space, rd, slot;

    assign length   = {len_hi_q, fifo_read_data};
    assign len_bad  = length == 16'd0 || length > 16'(MAX_FRAME);
    assign has_data = fifo_occu != '0;
    assign pop      = tx_valid && tx_ready;
    assign push     = inflight_q && state_q == PAYLOAD;
    assign space    = ({1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
    assign slot     = 1'(cnt_q - {1'b0, pop});

    assign fifo_read_enable = rd && !reset;
    assign tx_valid         = cnt_q != 2'd0;
    assign tx_data          = dat_q[0];
    assign tx_last          = tx_valid && lst_q[0];
    assign len_error        = len_error_q;
    assign busy             = state_q != IDLE;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_hi_q    <= '0;
            rem_q       <= '0;
            inflight_q  <= 1'b0;
            last_fl_q   <= 1'b0;
            cnt_q       <= '0;
            dat_q       <= '0;
            lst_q       <= '0;
            len_error_q <= 1'b0;
`ifdef FRAME_READER_IFG_EN
            gap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            rem_q       <= rem_d;
            inflight_q  <= inflight_d;
            last_fl_q   <= last_fl_d;
            cnt_q       <= cnt_d;
            dat_q       <= dat_d;
            lst_q       <= lst_d;
            len_error_q <= len_error_d;
`ifdef FRAME_READER_IFG_EN
            gap_q       <= gap_d;
`endif
        end
    end

    // Next state, header capture and remaining-byte accounting
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        rem_d       = rem_q;
        inflight_d  = rd;
        last_fl_d   = 1'b0;
        len_error_d = 1'b0;
`ifdef FRAME_READER_IFG_EN
        gap_d       = gap_q;
`endif
        case (state_q)
            IDLE: state_d = rd ? LEN_HI : IDLE;
            LEN_HI: begin
                len_hi_d = inflight_q ? fifo_read_data : len_hi_q;
                state_d  = rd ? LEN_LO : LEN_HI;
            end
            LEN_LO: begin
                len_error_d = len_bad;
                state_d     = length == 16'd0 ? IDLE : len_bad ? DISCARD : PAYLOAD;
                rem_d       = length - 16'(rd);
                last_fl_d   = rd && length == 16'd1;
            end
            PAYLOAD: begin
                rem_d     = rem_q - 16'(rd);
                last_fl_d = rd && rem_q == 16'd1;
`ifdef FRAME_READER_IFG_EN
                state_d   = pop && lst_q[0] ? GAP : PAYLOAD;
`else
                state_d   = pop && lst_q[0] ? IDLE : PAYLOAD;
`endif
            end
            DISCARD: begin
                rem_d   = rem_q - 16'(rd);
                state_d = rem_q == 16'd0 ? IDLE : DISCARD;
            end
`ifdef FRAME_READER_IFG_EN
            GAP: begin
                gap_d   = gap_q == GW'(GAP_CYCLES - 1) ? '0 : gap_q + 1'b1;
                state_d = gap_q == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Read strobe: only when data is available and the state still needs a byte
    always_comb begin
        rd = 1'b0;
        case (state_q)
            IDLE, LEN_HI: rd = has_data;
            LEN_LO:       rd = has_data && !len_bad;
            PAYLOAD:      rd = has_data && rem_q != 16'd0 && space;
            DISCARD:      rd = has_data && rem_q != 16'd0;
            default:      rd = 1'b0;
        endcase
    end

    // Skid buffer: head pops on handshake, arriving byte lands behind what remains
    always_comb begin
        dat_d = dat_q;
        lst_d = lst_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            dat_d[0] = dat_q[1];
            lst_d[0] = lst_q[1];
        end
        if (push) begin
            dat_d[slot] = fifo_read_data;
            lst_d[slot] = last_fl_q;
        end
    end
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: scoreboard bench with a queue-based FIFO model and frame-level expected stream.
module tb_fifo_frame_reader;
    localparam int MAX = 1518;
`ifdef FRAME_READER_IFG_EN
    localparam int IFG = 13;
`else
    localparam int IFG = 1;
`endif

    typedef struct packed { logic [7:0] d; logic l; } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] fifo_occu;
    logic       fifo_read_enable;
    logic [7:0] fifo_read_data;
    logic [7:0] tx_data;
    logic       tx_valid, tx_last, tx_ready, len_error, busy;

    logic [7:0] fq[$];
    exp_t       exp_q[$];
    int         rd_log[$];
    int         hs_log[$];
    int         checks = 0, passes = 0, err_cnt = 0, exp_err = 0, cyc = 0;
    int         rmode = 0, pat = 0;

    fifo_frame_reader dut (
        .clk(clk), .reset(reset), .fifo_occu(fifo_occu), .fifo_read_enable(fifo_read_enable),
        .fifo_read_data(fifo_read_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .len_error(len_error), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Monitor: compares every presented byte with the scoreboard head, logs reads and errors
    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_occu == 5'd0) chk("rd_when_empty", {31'd0, fifo_read_enable}, 0);
            if (fifo_read_enable) rd_log.push_back(cyc);
            if (len_error) err_cnt++;
            if (tx_valid) begin
                if (exp_q.size() == 0) chk("spurious_valid", {31'd0, tx_valid}, 0);
                else begin
                    chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q[0].d});
                    chk("tx_last", {31'd0, tx_last}, {31'd0, exp_q[0].l});
                    if (tx_ready) begin
                        void'(exp_q.pop_front());
                        hs_log.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic upd();
        fifo_occu = fq.size() > 16 ? 5'd16 : 5'(fq.size());
    endtask

    task automatic cycle();
        logic rd;
        @(negedge clk);
        rd = fifo_read_enable;
        @(posedge clk);
        #1;
        if (rd && fq.size() != 0) fifo_read_data = fq.pop_front();
        upd();
        tx_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : rmode == 2 ? (pat % 3 == 0) : 1'b0;
        pat++;
    endtask

    task automatic send(input int len, input logic [7:0] pl[$]);
        logic [7:0] b;
        fq.push_back(8'(len >> 8));
        fq.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = i < pl.size() ? pl[i] : 8'($urandom);
            fq.push_back(b);
            if (len <= MAX) exp_q.push_back('{b, i == len - 1});
        end
        if (len == 0 || len > MAX) exp_err++;
        upd();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || busy) && n < bound) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        chk("drain", 32'(exp_q.size() + fq.size()) + {31'd0, busy}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] none[$];
        logic [7:0] pl[$];
        logic [7:0] b2, b3;
        int r0, h0, e0, r1, h, nxt;
        reset = 1'b1;
        tx_ready = 1'b0;
        fifo_read_data = 8'd0;
        fifo_occu = 5'd0;
        send(2, none);
        repeat (2) @(negedge clk);
        chk("rst_rd_en", {31'd0, fifo_read_enable}, 0);
        chk("rst_valid", {31'd0, tx_valid}, 0);
        chk("rst_last", {31'd0, tx_last}, 0);
        chk("rst_data", {24'd0, tx_data}, 0);
        chk("rst_len_err", {31'd0, len_error}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        tx_ready = 1'b1;
        drain(100);

        // Basic 3-byte frame at full rate
        r0 = rd_log.size(); h0 = hs_log.size(); e0 = err_cnt;
        pl = '{8'hAA, 8'hBB, 8'hCC};
        send(3, pl);
        drain(100);
        chk("latency", 32'(hs_log[h0] - rd_log[r0]), 4);
        chk("back_to_back", 32'(hs_log[h0 + 2] - hs_log[h0]), 2);
        chk("basic_reads", 32'(rd_log.size() - r0), 5);
        chk("basic_no_err", 32'(err_cnt - e0), 0);

        // Same frame under 1,0,0 back-pressure
        rmode = 2; pat = 0;
        r0 = rd_log.size();
        send(3, pl);
        drain(100);
        chk("stall_reads", 32'(rd_log.size() - r0), 5);
        rmode = 0;

        // Zero-length header, then a 1-byte frame
        e0 = err_cnt;
        send(0, none);
        pl = '{8'h55};
        send(1, pl);
        drain(100);
        chk("zero_len_err", 32'(err_cnt - e0), 1);

        // Oversize header discarded, then a 1-byte frame
        e0 = err_cnt;
        send(1536, none);
        pl = '{8'h77};
        send(1, pl);
        drain(5000);
        chk("oversize_err", 32'(err_cnt - e0), 1);

        // FIFO runs dry after 2 of 4 payload bytes
        r0 = rd_log.size();
        send(4, none);
        b3 = fq.pop_back();
        b2 = fq.pop_back();
        upd();
        repeat (5) cycle();
        r1 = rd_log.size();
        repeat (10) cycle();
        chk("underflow_no_read", 32'(rd_log.size() - r1), 0);
        chk("underflow_busy", {31'd0, busy}, 1);
        fq.push_back(b2);
        fq.push_back(b3);
        upd();
        drain(100);
        chk("underflow_reads", 32'(rd_log.size() - r0), 6);

        // Back-to-back 1-byte frames: spacing from last handshake to next header read
        h0 = hs_log.size();
        pl = '{8'hA1};
        send(1, pl);
        pl = '{8'hA2};
        send(1, pl);
        drain(200);
        h = hs_log[h0];
        nxt = -1;
        foreach (rd_log[i]) if (nxt < 0 && rd_log[i] > h) nxt = rd_log[i];
        chk("ifg_spacing", 32'(nxt - h), 32'(IFG));

        // Randomized frames with random back-pressure and occasional bad headers
        rmode = 1;
        e0 = err_cnt;
        exp_err = 0;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 9) == 0) send($urandom_range(0, 1) != 0 ? 0 : int'($urandom_range(1519, 1530)), none);
            else send(int'($urandom_range(1, 24)), none);
        end
        drain(20000);
        chk("random_errs", 32'(err_cnt - e0), 32'(exp_err));

        // Reset in the middle of a stalled payload
        rmode = 3;
        send(8, none);
        repeat (8) cycle();
        chk("pre_reset_valid", {31'd0, tx_valid}, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, tx_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_rd_en", {31'd0, fifo_read_enable}, 0);
        chk("mid_rst_data", {24'd0, tx_data}, 0);
        chk("mid_rst_last", {31'd0, tx_last}, 0);
        fq.delete();
        exp_q.delete();
        upd();
        cycle();
        cycle();
        reset = 1'b0;
        rmode = 0;
        send(2, none);
        drain(100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Read-side consumer for the switch's async FIFO; runs entirely in the FIFO read clock domain.
- Drains length-prefixed frames (2-byte big-endian length header, then payload bytes) from the FIFO read port and presents the payload as a valid/ready byte stream with a last marker toward the egress MAC/port logic.
- Absorbs the FIFO's one-cycle registered read latency with a 2-entry skid buffer so tx_ready back-pressure never loses or duplicates a byte.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; occupancy input is ADDR_WIDTH+1 bits.
- MAX_FRAME, 1518, largest legal payload length in bytes; longer headers are discarded.
- GAP_CYCLES, 12, idle cycles inserted after each frame when the optional feature is compiled in.

Ports:
- clk  in  1  read-domain clock (connects to FIFO rclk).
- reset  in  1  asynchronous, active-high reset.
- fifo_occu  in  ADDR_WIDTH+1  FIFO read-side occupancy (fifo_occu_out).
- fifo_read_enable  out  1  read strobe to FIFO; data appears on fifo_read_data the following cycle.
- fifo_read_data  in  8  FIFO registered read data.
- tx_data  out  8  payload byte.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  marks final payload byte of a frame; qualified by tx_valid.
- tx_ready  in  1  downstream accepts byte when tx_valid && tx_ready.
- len_error  out  1  one-cycle pulse on a zero-length or oversize header.
- busy  out  1  high from first header read until frame end (including discard and gap).

Behaviour:
- Reset (async, active-high): state IDLE; fifo_read_enable, tx_valid, tx_last, len_error, busy = 0; tx_data = 0; skid buffer empty; length counter = 0.
- Read issue rule: fifo_read_enable = 1 only when fifo_occu != 0, the FSM needs a byte, and (skid entries + reads in flight) < 2. At most 1 read in flight. Never read while fifo_occu == 0 (empty boundary).
- A byte issued at cycle t is captured from fifo_read_data at t+1.
- FSM states:
  - IDLE: issue read when fifo_occu != 0, then go to LEN_HI.
  - LEN_HI: captured byte -> length[15:8]; issue next read; go to LEN_LO.
  - LEN_LO: captured byte -> length[7:0]. If length == 0: pulse len_error, go to IDLE. If length > MAX_FRAME: pulse len_error, go to DISCARD. Otherwise go to PAYLOAD with remaining = length.
  - PAYLOAD: each captured byte enters the skid buffer; remaining decrements per issued read. The byte for which remaining was 1 at issue is tagged last. Once the tagged byte has left the skid buffer (handshake), go to GAP if the feature is enabled, else IDLE.
  - DISCARD: read and drop `length` bytes with no tx output, ignoring tx_ready; then go to IDLE.
  - GAP: see Optional Feature.
- Output stream:
  - tx_valid = skid buffer non-empty; tx_data/tx_last come from the head entry.
  - tx_data and tx_last are held stable while tx_valid && !tx_ready.
  - Push and pop in the same cycle are allowed and keep the count unchanged.
- Throughput: 1 byte/cycle sustained when tx_ready = 1 and fifo_occu stays nonzero. First payload tx_valid occurs 4 cycles after the first header read.
- Width rules: remaining counter is 16 bits and is compared unsigned. Lengths 1..MAX_FRAME are legal.
- busy: 1 in every state except IDLE.
- Mid-frame FIFO underflow (fifo_occu == 0 during PAYLOAD): stall reads; no timeout; resume when data arrives.
- Reset mid-frame: all state clears immediately. The FIFO is not rewound; the upstream reset is relied on to clear the FIFO too.

Optional Feature:
- Macro FRAME_READER_IFG_EN.
- Defined: after tx_last handshake, FSM enters GAP for exactly GAP_CYCLES cycles. No reads and tx_valid = 0 during GAP; busy = 1. Then go to IDLE.
- Undefined: GAP state and its counter are absent; next frame header read may issue in the cycle after the tx_last handshake.

Test Plan:
- FIFO holds 00 03 AA BB CC, tx_ready = 1 -> tx sees AA, BB, CC on consecutive cycles, tx_last only on CC, len_error = 0, busy returns 0.
- Same frame with tx_ready toggling 1,0,0,1,... -> bytes held stable while stalled, no loss or duplication, exactly 5 fifo_read_enable pulses total.
- Header 00 00 followed by frame 00 01 55 -> len_error pulses once, then tx emits 55 with tx_last.
- Header 06 00 (1536 > 1518) plus 1536 bytes, then 00 01 77 -> one len_error, no tx_valid during discard, then 77 with tx_last.
- fifo_occu drops to 0 after 2 of 4 payload bytes, refilled 10 cycles later -> fifo_read_enable stays 0 while empty, remaining 2 bytes delivered, tx_last on the 4th.
- With FRAME_READER_IFG_EN, back-to-back 1-byte frames -> exactly 12 cycles between first tx_last handshake and the next header read; assert reset mid-PAYLOAD -> outputs 0 in the same cycle.
